// File: rtl/tick_gen_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_bank_pkg
// Purpose  : Shared definitions for the tick generator bank: FSM state
//            encodings, default system clock rate and a channel-index width
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package tick_gen_bank_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIV    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // A single channel still needs a 1-bit index port.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_bank_if
// Purpose  : Control/status bundle of the tick generator bank.
//            master : frequency write request, enables, phase clear
//            slave  : write ready, tick outputs (and sq_out when
//                     TICK_GEN_SQUARE_OUT_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
interface tick_gen_bank_if
    import tick_gen_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int FREQ_W = 26,
    parameter int CH_W   = ch_width(NUM_CH)
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [CH_W-1:0]   wr_ch;
    logic [FREQ_W-1:0] wr_freq;
    logic [NUM_CH-1:0] en;
    logic              phase_clr;
    logic [NUM_CH-1:0] tick;

`ifdef TICK_GEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] sq_out;

    modport master (output wr_valid, wr_ch, wr_freq, en, phase_clr,
                    input  wr_ready, tick, sq_out);
    modport slave  (input  wr_valid, wr_ch, wr_freq, en, phase_clr,
                    output wr_ready, tick, sq_out);
`else
    modport master (output wr_valid, wr_ch, wr_freq, en, phase_clr,
                    input  wr_ready, tick);
    modport slave  (input  wr_valid, wr_ch, wr_freq, en, phase_clr,
                    output wr_ready, tick);
`endif

endinterface
`default_nettype wire

// File: rtl/tick_gen_bank_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_bank_seq_divider
// Purpose  : Restoring unsigned divider, one quotient bit per clock.
//            clk, rst  : clock, synchronous active-high reset
//            start     : load dividend and begin WIDTH iterations
//            dividend  : WIDTH-bit numerator (sampled on start)
//            divisor   : WIDTH+1-bit denominator (held stable while busy)
//            done      : high in the cycle whose closing edge writes the
//                        final quotient bit
//            quotient  : result, valid in the cycle after done
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen_bank_seq_divider #(
    parameter int WIDTH = 27
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH:0]   divisor,
    output logic                  done,
    output logic [WIDTH-1:0]      quotient
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;    // dividend bits shift out the top, quotient in at the bottom
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_trial >= divisor);
    assign w_diff  = w_trial - divisor;

    // The partial remainder never exceeds the dividend prefix, so it always
    // fits back into WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_cnt <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_rem <= WIDTH'(w_ge ? w_diff : w_trial);
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign done     = (r_cnt == CNT_W'(1));
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/tick_gen_bank.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_bank
// Purpose  : NUM_CH independent one-cycle tick generators, each programmed
//            at runtime in Hz. A shared sequential divider turns CLK_HZ/freq
//            into a per-channel period.
//            clk, rst : system clock, synchronous active-high reset
//            bus      : slave side of tick_gen_bank_if (write handshake,
//                       enables, phase clear, tick outputs)
//            Optional : TICK_GEN_SQUARE_OUT_EN adds bus.sq_out, a per-channel
//                       square wave toggling on every tick.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen_bank
    import tick_gen_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int FREQ_W = 26
) (
    input  wire logic      clk,
    input  wire logic      rst,
    tick_gen_bank_if.slave bus
);

    localparam int DIV_W = $clog2(CLK_HZ + 1);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CMP_W = ((FREQ_W > DIV_W) ? FREQ_W : DIV_W) + 1;

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [FREQ_W-1:0] r_freq;
    logic              w_start;
    logic              w_div_done;
    logic [DIV_W-1:0]  w_quotient;
    logic [DIV_W:0]    w_dvsr;
    logic [DIV_W-1:0]  w_new_div;
    logic              w_ch_ok;
    logic              w_too_fast;
    logic              w_commit;

    logic [DIV_W-1:0]  r_div [NUM_CH];
    logic [DIV_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_off;
    logic [NUM_CH-1:0] w_wrap;

    // ---------------- write handshake / divider sequencing ----------------
    assign bus.wr_ready = (r_state == S_IDLE);
    assign w_start      = (r_state == S_IDLE) && bus.wr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_freq  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_valid) begin
                        r_ch    <= bus.wr_ch;
                        r_freq  <= bus.wr_freq;
                        r_state <= S_DIV;
                    end
                end
                S_DIV:    if (w_div_done) r_state <= S_COMMIT;
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Frequencies above CLK_HZ are clamped below, so truncating them here
    // never affects a quotient that is actually used.
    assign w_dvsr = (DIV_W + 1)'(r_freq);

    tick_gen_bank_seq_divider #(.WIDTH(DIV_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (DIV_W'(CLK_HZ)),
        .divisor  (w_dvsr),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    assign w_ch_ok    = ({1'b0, r_ch} < (CH_W + 1)'(NUM_CH));
    assign w_too_fast = (CMP_W'(r_freq) > CMP_W'(CLK_HZ));
    assign w_new_div  = (r_freq == '0) ? '0 :
                        w_too_fast     ? DIV_W'(1) : w_quotient;
    assign w_commit   = (r_state == S_COMMIT) && w_ch_ok;

    // ---------------- per-channel counters ----------------
    always_comb begin
        w_hit  = '0;
        w_off  = '0;
        w_wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_hit[i]  = w_commit && (r_ch == CH_W'(i));
            w_off[i]  = !bus.en[i] || (r_div[i] == '0);
            // Commit and phase clear both override a wrap on this edge.
            w_wrap[i] = !w_hit[i] && !bus.phase_clr && !w_off[i] &&
                        (r_cnt[i] == r_div[i] - DIV_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit[i]) r_div[i] <= w_new_div;
                if (w_hit[i] || bus.phase_clr || w_off[i] || w_wrap[i])
                    r_cnt[i] <= '0;
                else
                    r_cnt[i] <= r_cnt[i] + DIV_W'(1);
            end
            r_tick <= w_wrap;
        end
    end

    assign bus.tick = r_tick;

`ifdef TICK_GEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] r_sq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.phase_clr || w_off[i]) r_sq[i] <= 1'b0;
                else if (w_wrap[i])            r_sq[i] <= ~r_sq[i];
            end
        end
    end

    assign bus.sq_out = r_sq;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_gen_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_gen_bank
// Purpose  : Self-checking bench for tick_gen_bank at CLK_HZ=1000 (DIV_W=10).
//            A behavioural model predicts, per clock edge, the tick vector,
//            wr_ready and (with TICK_GEN_SQUARE_OUT_EN) sq_out; predictions
//            are queued as stimulus is applied and compared on the falling
//            edge after the DUT updates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_gen_bank;
    import tick_gen_bank_pkg::*;

    localparam int NUM_CH = 5;
    localparam int CLK_HZ = 1000;
    localparam int FREQ_W = 13;
    localparam int DIV_W  = 10;
    localparam int CH_W   = ch_width(NUM_CH);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tick_gen_bank_if #(.NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .CH_W(CH_W)) bus ();

    tick_gen_bank #(.NUM_CH(NUM_CH), .CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic              ready;
        logic [NUM_CH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // model state
    int m_div   [NUM_CH];
    int m_phase [NUM_CH];
    bit m_sq    [NUM_CH];
    int m_busy    = 0;
    int m_ch      = 0;
    int m_freq    = 0;
    int m_accepts = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int exp_div(input int f);
        if (f == 0)      return 0;
        if (f > CLK_HZ)  return 1;
        return CLK_HZ / f;
    endfunction

    // Predict the outputs produced by the coming rising edge using the
    // inputs currently applied, then queue the prediction.
    task automatic step();
        exp_t e;
        bit   commit;
        bit   off;
        commit = 1'b0;
        e.tick = '0;
        e.sq   = '0;
        if (rst) begin
            m_busy = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 0; m_phase[i] = 0; m_sq[i] = 1'b0;
            end
        end else begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) commit = 1'b1;
            end else if (bus.wr_valid) begin
                m_busy = DIV_W + 1;
                m_ch   = int'(bus.wr_ch);
                m_freq = int'(bus.wr_freq);
                m_accepts++;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                off = !bus.en[i] || (m_div[i] == 0);
                if (commit && m_ch == i) begin
                    m_div[i]   = exp_div(m_freq);
                    m_phase[i] = 0;
                end else if (bus.phase_clr || off) begin
                    m_phase[i] = 0;
                end else begin
                    m_phase[i]++;
                    if (m_phase[i] == m_div[i]) begin
                        m_phase[i] = 0;
                        e.tick[i]  = 1'b1;
                    end
                end
                if (bus.phase_clr || off) m_sq[i] = 1'b0;
                else if (e.tick[i])       m_sq[i] = ~m_sq[i];
                e.sq[i] = m_sq[i];
            end
        end
        e.ready = (m_busy == 0);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_write(input int ch, input int freq);
        bus.wr_valid = 1'b1;
        bus.wr_ch    = CH_W'(ch);
        bus.wr_freq  = FREQ_W'(freq);
        step();
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 2 * DIV_W && m_busy > 0; k++) step();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("tick", 64'(bus.tick), 64'(e.tick));
            check_val("wr_ready", 64'(bus.wr_ready), 64'(e.ready));
`ifdef TICK_GEN_SQUARE_OUT_EN
            check_val("sq_out", 64'(bus.sq_out), 64'(e.sq));
`endif
        end
    end

    initial begin
        int acc0;
        rst           = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_ch     = '0;
        bus.wr_freq   = '0;
        bus.en        = '1;
        bus.phase_clr = 1'b0;
        run(3);
        rst = 1'b0;
        run(100);                       // idle: no ticks, always ready

        do_write(0, 250);               // period 4
        run(40);
        do_write(1, 3);                 // period 333
        run(700);
        do_write(2, 0);                 // channel off
        do_write(3, 5000);              // clamped to every cycle
        run(20);
        do_write(6, 10);                // out of range: nothing changes
        run(50);

        bus.en[0] = 1'b0;               // gate ch0
        run(10);
        bus.en[0] = 1'b1;
        run(12);

        run(2);                         // ch0 mid-period
        bus.phase_clr = 1'b1;
        step();
        bus.phase_clr = 1'b0;
        run(20);

        acc0          = m_accepts;      // wr_valid held across two writes
        bus.wr_valid  = 1'b1;
        bus.wr_ch     = CH_W'(0);
        bus.wr_freq   = FREQ_W'(500);
        step();
        bus.wr_ch     = CH_W'(4);
        bus.wr_freq   = FREQ_W'(100);
        for (int k = 0; k < 40 && m_accepts < acc0 + 2; k++) step();
        bus.wr_valid  = 1'b0;
        for (int k = 0; k < 2 * DIV_W && m_busy > 0; k++) step();
        run(30);

        bus.wr_valid = 1'b1;            // reset in the middle of a division
        bus.wr_ch    = CH_W'(0);
        bus.wr_freq  = FREQ_W'(100);
        step();
        bus.wr_valid = 1'b0;
        run(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(30);

        do_write(0, 250);               // square wave period 8
        run(30);
        do_write(0, 0);
        run(20);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
